// File: rtl/carpma_istek_kuyrugu.sv
// Operand-pair request FIFO in front of the memoised multiplier: buffers {sayi1,sayi2}
// pairs and issues one pair per two-cycle ARA/HESAPLA window, holding operands stable.
module carpma_istek_kuyrugu #(
  parameter int VERI_GENISLIGI  = 32,
  parameter int DERINLIK        = 8,
  parameter int ADRES_GENISLIGI = 3,
  parameter int SAYAC_GENISLIGI = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       giris_gecerli,
  output logic                       giris_hazir,
  input  logic [VERI_GENISLIGI-1:0]  giris_sayi1,
  input  logic [VERI_GENISLIGI-1:0]  giris_sayi2,
  output logic [VERI_GENISLIGI-1:0]  sayi1,
  output logic [VERI_GENISLIGI-1:0]  sayi2,
  output logic                       sonuc_gecerli,
  output logic [ADRES_GENISLIGI:0]   doluluk,
  output logic                       bos,
  output logic                       dolu,
  output logic [SAYAC_GENISLIGI-1:0] islem_sayaci
);

  localparam logic [ADRES_GENISLIGI-1:0] SON_ADRES = ADRES_GENISLIGI'(DERINLIK - 1);
  localparam logic [ADRES_GENISLIGI:0]   TAM_DOLU  = (ADRES_GENISLIGI + 1)'(DERINLIK);

  typedef enum logic [1:0] {BOS, ARA, HESAPLA} durum_t;

  durum_t                       r_durum, w_durum_sonraki;
  logic [2*VERI_GENISLIGI-1:0]  r_bellek [DERINLIK];
  logic [ADRES_GENISLIGI-1:0]   r_yaz, r_oku;
  logic [ADRES_GENISLIGI:0]     r_doluluk;
  logic [VERI_GENISLIGI-1:0]    r_sayi1, r_sayi2;
  logic                         r_sonuc_gecerli;
  logic [SAYAC_GENISLIGI-1:0]   r_islem_sayaci;
  logic                         w_yaz, w_oku, w_bos, w_dolu;

  // Explicit compare so any DERINLIK works, not only powers of two.
  function automatic logic [ADRES_GENISLIGI-1:0] sonraki(input logic [ADRES_GENISLIGI-1:0] p);
    return (p == SON_ADRES) ? '0 : p + ADRES_GENISLIGI'(1);
  endfunction

  assign w_bos  = (r_doluluk == '0);
  assign w_dolu = (r_doluluk == TAM_DOLU);
  assign w_yaz  = giris_gecerli && !w_dolu;

  always_comb begin
    w_durum_sonraki = r_durum;
    w_oku           = 1'b0;
    case (r_durum)
      BOS: begin
        if (!w_bos) begin
          w_durum_sonraki = ARA;
          w_oku           = 1'b1;
        end
      end
      ARA:     w_durum_sonraki = HESAPLA;
      HESAPLA: begin
        if (!w_bos) begin
          w_durum_sonraki = ARA;
          w_oku           = 1'b1;
        end else begin
          w_durum_sonraki = BOS;
        end
      end
      default: w_durum_sonraki = BOS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_durum         <= BOS;
      r_yaz           <= '0;
      r_oku           <= '0;
      r_doluluk       <= '0;
      r_sayi1         <= '0;
      r_sayi2         <= '0;
      r_sonuc_gecerli <= 1'b0;
      r_islem_sayaci  <= '0;
    end else begin
      r_durum         <= w_durum_sonraki;
      r_sonuc_gecerli <= (w_durum_sonraki == HESAPLA);
      if (w_yaz) r_yaz <= sonraki(r_yaz);
      if (w_oku) begin
        r_oku              <= sonraki(r_oku);
        {r_sayi1, r_sayi2} <= r_bellek[r_oku];
      end
      case ({w_yaz, w_oku})
        2'b10:   r_doluluk <= r_doluluk + 1'b1;
        2'b01:   r_doluluk <= r_doluluk - 1'b1;
        default: r_doluluk <= r_doluluk;
      endcase
      // An operation completes on the edge leaving HESAPLA.
      if (r_durum == HESAPLA) r_islem_sayaci <= r_islem_sayaci + 1'b1;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_yaz) r_bellek[r_yaz] <= {giris_sayi1, giris_sayi2};
  end

  assign giris_hazir   = !w_dolu;
  assign sayi1         = r_sayi1;
  assign sayi2         = r_sayi2;
  assign sonuc_gecerli = r_sonuc_gecerli;
  assign doluluk       = r_doluluk;
  assign bos           = w_bos;
  assign dolu          = w_dolu;
  assign islem_sayaci  = r_islem_sayaci;

endmodule

// File: tb/tb_carpma_istek_kuyrugu.sv
// Directed bench for carpma_istek_kuyrugu; a second instance with a 4-bit counter
// shares the same stimulus to exercise counter wrap.
module tb_carpma_istek_kuyrugu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        giris_gecerli = 1'b0;
  logic [31:0] giris_sayi1 = '0, giris_sayi2 = '0;
  logic        giris_hazir, sonuc_gecerli, bos, dolu;
  logic [31:0] sayi1, sayi2;
  logic [3:0]  doluluk;
  logic [15:0] islem_sayaci;

  logic        d4_hazir, d4_sonuc, d4_bos, d4_dolu;
  logic [31:0] d4_sayi1, d4_sayi2;
  logic [3:0]  d4_doluluk;
  logic [3:0]  d4_sayac;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  carpma_istek_kuyrugu #(.VERI_GENISLIGI(32), .DERINLIK(8), .ADRES_GENISLIGI(3), .SAYAC_GENISLIGI(16)) u_dut (
    .clk(clk), .rst(rst), .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
    .giris_sayi1(giris_sayi1), .giris_sayi2(giris_sayi2), .sayi1(sayi1), .sayi2(sayi2),
    .sonuc_gecerli(sonuc_gecerli), .doluluk(doluluk), .bos(bos), .dolu(dolu),
    .islem_sayaci(islem_sayaci)
  );

  carpma_istek_kuyrugu #(.VERI_GENISLIGI(32), .DERINLIK(8), .ADRES_GENISLIGI(3), .SAYAC_GENISLIGI(4)) u_dut4 (
    .clk(clk), .rst(rst), .giris_gecerli(giris_gecerli), .giris_hazir(d4_hazir),
    .giris_sayi1(giris_sayi1), .giris_sayi2(giris_sayi2), .sayi1(d4_sayi1), .sayi2(d4_sayi2),
    .sonuc_gecerli(d4_sonuc), .doluluk(d4_doluluk), .bos(d4_bos), .dolu(d4_dolu),
    .islem_sayaci(d4_sayac)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pair(input int mode, input int i);
    if (mode == 0) return {32'h3300_0000 + 32'(i), 32'h4400_0000 + 32'(i * 3)};
    return {32'(i + 1), 32'(20 - i)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({sayi1, sayi2} !== 64'h0 || sonuc_gecerli !== 1'b0 || doluluk !== 4'd0 ||
        bos !== 1'b1 || giris_hazir !== 1'b1 || islem_sayaci !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: sayi=%h/%h sg=%b dol=%0d bos=%b hz=%b cnt=%0d, required all zero, bos=1 hz=1",
               sayi1, sayi2, sonuc_gecerli, doluluk, bos, giris_hazir, islem_sayaci);
    end
    tick();
    rst = 1'b0;
    // Six consecutive pushes leave the FSM in ARA with three entries queued.
    for (int i = 0; i < 6; i++) begin
      giris_gecerli = 1'b1;
      giris_sayi1   = 32'hA000_0000 + 32'(i);
      giris_sayi2   = 32'hB000_0000 + 32'(i);
      tick();
    end
    giris_gecerli = 1'b0;
    n_checks++;
    if (doluluk !== 4'd3 || sayi1 !== 32'hA000_0002 || sonuc_gecerli !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_ara: dol=%0d sayi1=%h sg=%b, required 3 a0000002 0", doluluk, sayi1, sonuc_gecerli);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sayi1, sayi2} !== 64'h0 || sonuc_gecerli !== 1'b0 || doluluk !== 4'd0 ||
        giris_hazir !== 1'b1 || bos !== 1'b1 || islem_sayaci !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: sayi=%h/%h sg=%b dol=%0d hz=%b bos=%b cnt=%0d, required zeros hz=1 bos=1",
               sayi1, sayi2, sonuc_gecerli, doluluk, giris_hazir, bos, islem_sayaci);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (sonuc_gecerli !== 1'b0 || doluluk !== 4'd0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: cycle %0d sg=%b dol=%0d, required 0 0", c, sonuc_gecerli, doluluk);
      end
    end
  endtask

  task automatic test_single();
    giris_gecerli = 1'b1;
    giris_sayi1   = 32'h3000_0002;
    giris_sayi2   = 32'h2000_0005;
    tick();                       // edge k
    giris_gecerli = 1'b0;
    n_checks++;
    if (sonuc_gecerli !== 1'b0 || doluluk !== 4'd1) begin
      n_fail++;
      $display("FAIL single_k: sg=%b dol=%0d, required 0 1", sonuc_gecerli, doluluk);
    end
    tick();                       // k+1: ARA
    n_checks++;
    if (sayi1 !== 32'h3000_0002 || sayi2 !== 32'h2000_0005 || sonuc_gecerli !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ara: sayi=%h/%h sg=%b, required 30000002/20000005 0", sayi1, sayi2, sonuc_gecerli);
    end
    tick();                       // k+2: HESAPLA
    n_checks++;
    if (sayi1 !== 32'h3000_0002 || sayi2 !== 32'h2000_0005 || sonuc_gecerli !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hesapla: sayi=%h/%h sg=%b, required 30000002/20000005 1", sayi1, sayi2, sonuc_gecerli);
    end
    tick();                       // k+3: BOS
    n_checks++;
    if (sonuc_gecerli !== 1'b0 || islem_sayaci !== 16'd1 || bos !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: sg=%b cnt=%0d bos=%b, required 0 1 1", sonuc_gecerli, islem_sayaci, bos);
    end
    tick();
    n_checks++;
    if (sayi1 !== 32'h3000_0002 || sayi2 !== 32'h2000_0005 || sonuc_gecerli !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: sayi=%h/%h sg=%b, required held pair 0", sayi1, sayi2, sonuc_gecerli);
    end
  endtask

  // Drives n pairs (continuous or gated by patt) and checks issue order against a queue.
  task automatic stream(input int n, input int mode, input bit bursty, input logic [31:0] patt,
                        output int got, output bit saw_full);
    logic [63:0] q[$];
    logic [63:0] exp;
    int sent, cyc, last;
    bit acc;
    sent = 0; got = 0; cyc = 0; last = -1; saw_full = 1'b0;
    while ((sent < n || got < n) && cyc < 400) begin
      giris_gecerli = (sent < n) && (!bursty || patt[cyc % 32]);
      {giris_sayi1, giris_sayi2} = pair(mode, sent);
      acc = giris_gecerli && giris_hazir;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(pair(mode, sent));
        sent++;
      end
      if (dolu) begin
        saw_full = 1'b1;
        n_checks++;
        if (giris_hazir !== 1'b0 || doluluk !== 4'd8) begin
          n_fail++;
          $display("FAIL full_flags: hz=%b dol=%0d, required 0 8", giris_hazir, doluluk);
        end
      end
      if (sonuc_gecerli === 1'b1) begin
        exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        n_checks++;
        if ({sayi1, sayi2} !== exp) begin
          n_fail++;
          $display("FAIL order_m%0d: result %0d got %h/%h, required %h/%h", mode, got, sayi1, sayi2, exp[63:32], exp[31:0]);
        end
        if (!bursty && last >= 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_fail++;
            $display("FAIL issue_gap: result %0d gap %0d cycles, required 2", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    giris_gecerli = 1'b0;
    if (cyc >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: sent %0d got %0d of %0d", sent, got, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int got;
    bit full;
    stream(18, 0, 1'b0, 32'hFFFF_FFFF, got, full);
    n_checks++;
    if (got != 18 || full !== 1'b1 || islem_sayaci !== 16'd19) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d full %b cnt %0d, required 18 1 19", got, full, islem_sayaci);
    end
  endtask

  task automatic test_wrap();
    int got;
    bit full;
    stream(20, 1, 1'b1, 32'b1101_0011_1110_0101_1011_0001_1111_0110, got, full);
    n_checks++;
    if (got != 20 || islem_sayaci !== 16'd39 || bos !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: got %0d cnt %0d bos %b, required 20 39 1", got, islem_sayaci, bos);
    end
  endtask

  task automatic test_push_pop();
    tick();
    giris_gecerli = 1'b1; giris_sayi1 = 32'h0000_00A1; giris_sayi2 = 32'h0000_00A2;
    tick();                                   // k: push A
    giris_gecerli = 1'b0;
    tick();                                   // k+1: pop A, ARA
    giris_gecerli = 1'b1; giris_sayi1 = 32'h0000_00B1; giris_sayi2 = 32'h0000_00B2;
    tick();                                   // k+2: HESAPLA, push B
    n_checks++;
    if (doluluk !== 4'd1 || sonuc_gecerli !== 1'b1 || sayi1 !== 32'h0000_00A1) begin
      n_fail++;
      $display("FAIL pp_setup: dol=%0d sg=%b sayi1=%h, required 1 1 a1", doluluk, sonuc_gecerli, sayi1);
    end
    giris_sayi1 = 32'h0000_00C1; giris_sayi2 = 32'h0000_00C2;
    tick();                                   // k+3: pop B, push C
    giris_gecerli = 1'b0;
    n_checks++;
    if (doluluk !== 4'd1 || sonuc_gecerli !== 1'b0 || sayi1 !== 32'h0000_00B1 || sayi2 !== 32'h0000_00B2) begin
      n_fail++;
      $display("FAIL pp_same_edge: dol=%0d sg=%b sayi=%h/%h, required 1 0 b1/b2", doluluk, sonuc_gecerli, sayi1, sayi2);
    end
    tick();
    n_checks++;
    if (sonuc_gecerli !== 1'b1 || sayi1 !== 32'h0000_00B1 || doluluk !== 4'd1) begin
      n_fail++;
      $display("FAIL pp_b_result: sg=%b sayi1=%h dol=%0d, required 1 b1 1", sonuc_gecerli, sayi1, doluluk);
    end
    tick();
    n_checks++;
    if (sonuc_gecerli !== 1'b0 || sayi1 !== 32'h0000_00C1 || doluluk !== 4'd0) begin
      n_fail++;
      $display("FAIL pp_c_ara: sg=%b sayi1=%h dol=%0d, required 0 c1 0", sonuc_gecerli, sayi1, doluluk);
    end
    tick();
    n_checks++;
    if (sonuc_gecerli !== 1'b1 || sayi2 !== 32'h0000_00C2) begin
      n_fail++;
      $display("FAIL pp_c_result: sg=%b sayi2=%h, required 1 c2", sonuc_gecerli, sayi2);
    end
    tick();
    n_checks++;
    if (sonuc_gecerli !== 1'b0 || bos !== 1'b1 || islem_sayaci !== 16'd42) begin
      n_fail++;
      $display("FAIL pp_done: sg=%b bos=%b cnt=%0d, required 0 1 42", sonuc_gecerli, bos, islem_sayaci);
    end
  endtask

  task automatic test_counter_wrap();
    int sent, done, cyc;
    do_reset();
    sent = 0; done = 0; cyc = 0;
    while (done < 17 && cyc < 200) begin
      giris_gecerli = (sent < 17);
      giris_sayi1 = 32'(sent); giris_sayi2 = 32'(sent + 100);
      if (giris_gecerli && giris_hazir) sent++;
      tick();
      cyc++;
      n_checks++;
      if (d4_sayac !== 4'(done)) begin
        n_fail++;
        $display("FAIL counter4: after %0d ops got %h, required %h", done, d4_sayac, 4'(done));
      end
      if (sonuc_gecerli === 1'b1) done++;
    end
    giris_gecerli = 1'b0;
    tick();
    n_checks++;
    if (cyc >= 200 || d4_sayac !== 4'h1 || islem_sayaci !== 16'd17) begin
      n_fail++;
      $display("FAIL counter_final: cnt4=%h cnt16=%0d cyc=%0d, required 1 17", d4_sayac, islem_sayaci, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_push_pop();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
